// File: rtl/fpga_memory_mc.sv
// Multi-channel memory bridge: round-robin arbiter in front of a local scratch
// RAM and a MicroBlaze port driven through an ack/done edge handshake.
//
// state        | meaning
// IDLE         | pick next requester, latch its request
// WR_ACK_WAIT  | MB write issued, waiting for mb_ack rise
// WR_DONE_WAIT | MB write accepted, waiting for mb_done rise
// RD_ACK_WAIT  | MB read issued, waiting for mb_ack rise
// RD_DONE_WAIT | MB read accepted, waiting for mb_done rise
// LOCAL        | single-cycle scratch RAM access
// RESP         | one-cycle resp_ack pulse to the granted channel
module fpga_memory_mc #(
    parameter int NUM_CH   = 4,
    parameter int DW       = 32,
    parameter int TAG_W    = 7,
    parameter int LOCAL_AW = 12,
    parameter int TIMEOUT  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       req_wr_en,
    input  logic [NUM_CH-1:0]       req_rd_en,
    input  logic [NUM_CH*32-1:0]    req_addr,
    input  logic [NUM_CH*DW-1:0]    req_wr_data,
    input  logic [NUM_CH*TAG_W-1:0] req_tag,
    output logic [NUM_CH-1:0]       resp_ack,
    output logic [DW-1:0]           resp_rd_data,
    output logic [TAG_W-1:0]        resp_tag,
    output logic                    resp_err,
    output logic [3:0]              mb_op,
    output logic [31:0]             mb_addr,
    output logic [DW-1:0]           mb_wr_data,
    input  logic [DW-1:0]           mb_rd_data,
    input  logic                    mb_ack,
    input  logic                    mb_done
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

    // Wait-state encodings double as the MB op code.
    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        WR_ACK_WAIT  = 4'd1,
        WR_DONE_WAIT = 4'd2,
        RD_ACK_WAIT  = 4'd4,
        RD_DONE_WAIT = 4'd5,
        LOCAL        = 4'd8,
        RESP         = 4'd9
    } state_t;

    state_t            state;
    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     ch_q;
    logic              op_wr;
    logic [TAG_W-1:0]  tag_q;
    logic [TW-1:0]     tmr;
    logic              mb_ack_q;
    logic              mb_done_q;
    logic              ack_rise;
    logic              done_rise;
    logic [NUM_CH-1:0] ack_vec;
    logic              ram_we;

    logic [DW-1:0]     ram [0:2**LOCAL_AW-1];

    logic              gnt_found;
    logic [CW-1:0]     gnt_ch;
    logic              gnt_wr;
    logic [31:0]       gnt_addr;
    logic [DW-1:0]     gnt_data;
    logic [TAG_W-1:0]  gnt_tag;
    int                c;

    assign ack_rise  = mb_ack & ~mb_ack_q;
    assign done_rise = mb_done & ~mb_done_q;
    assign ack_vec   = NUM_CH'(1) << ch_q;
    assign ram_we    = (state == LOCAL) && op_wr && !rst;

    // Search starts one past the last grant so every channel gets a turn.
    always_comb begin
        gnt_found = 1'b0;
        gnt_ch    = '0;
        gnt_wr    = 1'b0;
        gnt_addr  = '0;
        gnt_data  = '0;
        gnt_tag   = '0;
        c         = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            c = (int'(rr_ptr) + i) % NUM_CH;
            if (!gnt_found && (req_wr_en[c] || req_rd_en[c])) begin
                gnt_found = 1'b1;
                gnt_ch    = CW'(c);
                gnt_wr    = req_wr_en[c];
                gnt_addr  = req_addr[32*c +: 32];
                gnt_data  = req_wr_data[DW*c +: DW];
                gnt_tag   = req_tag[TAG_W*c +: TAG_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            ram[mb_addr[LOCAL_AW-1:0]] <= mb_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= CW'(NUM_CH - 1);
            ch_q         <= '0;
            op_wr        <= 1'b0;
            tag_q        <= '0;
            tmr          <= '0;
            mb_ack_q     <= 1'b0;
            mb_done_q    <= 1'b0;
            resp_ack     <= '0;
            resp_rd_data <= '0;
            resp_tag     <= '0;
            resp_err     <= 1'b0;
            mb_op        <= '0;
            mb_addr      <= '0;
            mb_wr_data   <= '0;
        end else begin
            mb_ack_q     <= mb_ack;
            mb_done_q    <= mb_done;
            // Response fields are one-cycle pulses; only the transition into RESP sets them.
            resp_ack     <= '0;
            resp_rd_data <= '0;
            resp_tag     <= '0;
            resp_err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        rr_ptr     <= gnt_ch;
                        ch_q       <= gnt_ch;
                        op_wr      <= gnt_wr;
                        tag_q      <= gnt_tag;
                        mb_addr    <= gnt_addr;
                        mb_wr_data <= gnt_data;
                        tmr        <= TMR_LOAD;
                        if (gnt_addr[31:LOCAL_AW] == '0) begin
                            state <= LOCAL;
                        end else if (gnt_wr) begin
                            state <= WR_ACK_WAIT;
                            mb_op <= WR_ACK_WAIT;
                        end else begin
                            state <= RD_ACK_WAIT;
                            mb_op <= RD_ACK_WAIT;
                        end
                    end
                end
                LOCAL: begin
                    if (!op_wr)
                        resp_rd_data <= ram[mb_addr[LOCAL_AW-1:0]];
                    resp_ack <= ack_vec;
                    resp_tag <= tag_q;
                    state    <= RESP;
                end
                WR_ACK_WAIT, RD_ACK_WAIT: begin
                    if (ack_rise) begin
                        state <= op_wr ? WR_DONE_WAIT : RD_DONE_WAIT;
                        mb_op <= op_wr ? WR_DONE_WAIT : RD_DONE_WAIT;
                        tmr   <= TMR_LOAD;
                    end else if (tmr == '0) begin
                        resp_ack <= ack_vec;
                        resp_tag <= tag_q;
                        resp_err <= 1'b1;
                        mb_op    <= '0;
                        state    <= RESP;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                WR_DONE_WAIT, RD_DONE_WAIT: begin
                    if (done_rise) begin
                        if (!op_wr)
                            resp_rd_data <= mb_rd_data;
                        resp_ack <= ack_vec;
                        resp_tag <= tag_q;
                        mb_op    <= '0;
                        state    <= RESP;
                    end else if (tmr == '0) begin
                        resp_ack <= ack_vec;
                        resp_tag <= tag_q;
                        resp_err <= 1'b1;
                        mb_op    <= '0;
                        state    <= RESP;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
